// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response handshakes and memory port of the load/store stage.
// slave is the lsu_ctrl view; master is the pipeline-plus-memory view.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_ce;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store stage driving a doubleword-wide memory port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests skip memory and respond with resp_err.
module lsu_ctrl #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [2:0]  off;
  logic        accept;
  logic        last;
  logic        misalign;
  logic [7:0]  mask;
  logic [63:0] raw;
  logic [63:0] ext;

  assign off    = addr_q[2:0];
  assign accept = (state_q == IDLE) && bus.req_valid;
  assign last   = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  assign bus.mem_addr   = {addr_q[63:3], 3'b000};
  assign bus.mem_wdata  = wdata_q << {off, 3'b000};
  assign bus.resp_rdata = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'd1:    misalign = bus.req_addr[0];
      2'd2:    misalign = |bus.req_addr[1:0];
      2'd3:    misalign = |bus.req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end

  assign bus.resp_err = err_q;
`else
  assign misalign     = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_comb begin
    mask = '0;
    case (size_q)
      2'd0:    mask = 8'h01 << off;
      2'd1:    mask = 8'h03 << off;
      2'd2:    mask = 8'h0F << off;
      default: mask = 8'hFF;
    endcase
  end

  // Bytes past the doubleword boundary shift in as zero before extension.
  always_comb begin
    raw = bus.mem_rdata >> {off, 3'b000};
    ext = '0;
    case (size_q)
      2'd0:    ext = uns_q ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'd1:    ext = uns_q ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2:    ext = uns_q ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_ce     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wmask  = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = misalign ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_ce    = 1'b1;
        bus.mem_wmask = mask;
        // Write strobe only on the final wait cycle so each store lands once.
        bus.mem_we    = we_q && last;
        if (last) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q + 4'd1;
      if (last) rdata_q <= we_q ? '0 : ext;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: one MEM_LAT=0 and one MEM_LAT=3 instance, each with a one-doubleword memory.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0_n = 1'b1;
  logic        rst3_n = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_ready = 1'b1;
  logic [63:0] mem0 = '0;
  logic [63:0] mem3 = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];

  logic        o_req_ready, o_resp_valid, o_err, o_ce, o_we;
  logic [63:0] o_rdata, o_addr, o_wdata;
  logic [7:0]  o_mask;

  lsu_ctrl_if i0();
  lsu_ctrl_if i3();

  lsu_ctrl #(.MEM_LAT(0)) u_lsu0 (.clk(clk), .rst_n(rst0_n), .bus(i0.slave));
  lsu_ctrl #(.MEM_LAT(3)) u_lsu3 (.clk(clk), .rst_n(rst3_n), .bus(i3.slave));

  always #5 clk = ~clk;

  assign i0.req_valid    = req_valid && !sel;
  assign i3.req_valid    = req_valid && sel;
  assign i0.req_we       = req_we;
  assign i3.req_we       = req_we;
  assign i0.req_addr     = req_addr;
  assign i3.req_addr     = req_addr;
  assign i0.req_wdata    = req_wdata;
  assign i3.req_wdata    = req_wdata;
  assign i0.req_size     = req_size;
  assign i3.req_size     = req_size;
  assign i0.req_unsigned = req_unsigned;
  assign i3.req_unsigned = req_unsigned;
  assign i0.resp_ready   = resp_ready;
  assign i3.resp_ready   = resp_ready;
  assign i0.mem_rdata    = mem0;
  assign i3.mem_rdata    = mem3;

  always_comb begin
    o_req_ready  = sel ? i3.req_ready  : i0.req_ready;
    o_resp_valid = sel ? i3.resp_valid : i0.resp_valid;
    o_rdata      = sel ? i3.resp_rdata : i0.resp_rdata;
    o_err        = sel ? i3.resp_err   : i0.resp_err;
    o_ce         = sel ? i3.mem_ce     : i0.mem_ce;
    o_we         = sel ? i3.mem_we     : i0.mem_we;
    o_addr       = sel ? i3.mem_addr   : i0.mem_addr;
    o_wdata      = sel ? i3.mem_wdata  : i0.mem_wdata;
    o_mask       = sel ? i3.mem_wmask  : i0.mem_wmask;
  end

  always @(posedge clk)
    if (i0.mem_ce && i0.mem_we)
      for (int b = 0; b < 8; b++)
        if (i0.mem_wmask[b]) mem0[8*b +: 8] <= i0.mem_wdata[8*b +: 8];

  always @(posedge clk)
    if (i3.mem_ce && i3.mem_we)
      for (int k = 0; k < 8; k++)
        if (i3.mem_wmask[k]) mem3[8*k +: 8] <= i3.mem_wdata[8*k +: 8];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty act=response exp=none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", o_rdata, e.rdata);
        check("resp_err", 64'(o_err), 64'(e.err));
      end
    end
  end

  task automatic run_req(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [1:0] sz, input logic uns, input logic [63:0] exp_rd,
                         input logic exp_err, input logic [7:0] exp_mask,
                         input logic [63:0] exp_mwd, input int unsigned hold);
    int unsigned lat, lat_exp, ce_exp, cycles, nce, nwe, we_at;
    exp_t e;
    lat     = sel ? 3 : 0;
    lat_exp = exp_err ? 1 : lat + 2;
    ce_exp  = exp_err ? 0 : lat + 1;
    cycles = 0; nce = 0; nwe = 0; we_at = 0;
    @(negedge clk);
    check("rdy_idle", 64'(o_req_ready), 64'd1);
    req_we = we; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    e.err = exp_err;
    e.rdata = exp_rd;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      cycles = k;
      if (o_ce) begin
        nce++;
        check("mem_addr", o_addr, {addr[63:3], 3'b000});
        check("mem_wmask", 64'(o_mask), 64'(exp_mask));
        check("mem_wdata", o_wdata, exp_mwd);
      end
      if (o_we) begin
        nwe++;
        we_at = nce;
      end
      if (o_resp_valid) break;
    end
    check("latency", 64'(cycles), 64'(lat_exp));
    check("ce_cycles", 64'(nce), 64'(ce_exp));
    check("we_pulses", 64'(nwe), (we && !exp_err) ? 64'd1 : 64'd0);
    if (nwe != 0) check("we_last", 64'(we_at), 64'(ce_exp));
    check("rdy_resp", 64'(o_req_ready), 64'd0);
    if (hold != 0) begin
      for (int h = 0; h < int'(hold); h++) begin
        @(negedge clk);
        check("hold_valid", 64'(o_resp_valid), 64'd1);
        check("hold_rdata", o_rdata, exp_rd);
        check("hold_err", 64'(o_err), 64'(exp_err));
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1 check("rdy_after", 64'(o_req_ready), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(o_resp_valid), 64'd0);
    check({tag, "_mem_ce"}, 64'(o_ce), 64'd0);
    check({tag, "_mem_we"}, 64'(o_we), 64'd0);
    check({tag, "_mem_wmask"}, 64'(o_mask), 64'd0);
    check({tag, "_mem_addr"}, o_addr, 64'd0);
    check({tag, "_mem_wdata"}, o_wdata, 64'd0);
    check({tag, "_resp_rdata"}, o_rdata, 64'd0);
    check({tag, "_resp_err"}, 64'(o_err), 64'd0);
  endtask

  initial begin
    int unsigned bad;
    #1 rst0_n = 1'b0; rst3_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; #1 check_reset_state("rst0");
    sel = 1'b1; #1 check_reset_state("rst3");
    @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1;

    // MEM_LAT=0 instance
    sel = 1'b0;
    run_req(1, 64'h8000_0000, 64'h1122334455667788, 2'd3, 0, 64'h0, 0, 8'hFF, 64'h1122334455667788, 0);
    run_req(0, 64'h8000_0000, 64'h0, 2'd3, 0, 64'h1122334455667788, 0, 8'hFF, 64'h0, 0);
    run_req(1, 64'h8000_0005, 64'hAB, 2'd0, 0, 64'h0, 0, 8'h20, 64'h0000AB0000000000, 0);
    run_req(0, 64'h8000_0005, 64'h0, 2'd0, 1, 64'hAB, 0, 8'h20, 64'h0, 0);
    run_req(0, 64'h8000_0005, 64'h0, 2'd0, 0, 64'hFFFFFFFFFFFFFFAB, 0, 8'h20, 64'h0, 0);
    run_req(1, 64'h8000_0000, 64'h80FF000000000000, 2'd3, 0, 64'h0, 0, 8'hFF, 64'h80FF000000000000, 0);
    run_req(0, 64'h8000_0007, 64'h0, 2'd0, 0, 64'hFFFFFFFFFFFFFF80, 0, 8'h80, 64'h0, 0);
    run_req(0, 64'h8000_0007, 64'h0, 2'd0, 1, 64'h80, 0, 8'h80, 64'h0, 0);
    run_req(0, 64'h8000_0006, 64'h0, 2'd1, 0, 64'hFFFFFFFFFFFF80FF, 0, 8'hC0, 64'h0, 0);
    run_req(0, 64'h8000_0004, 64'h0, 2'd2, 0, 64'hFFFFFFFF80FF0000, 0, 8'hF0, 64'h0, 0);
    run_req(0, 64'h8000_0004, 64'h0, 2'd2, 1, 64'h80FF0000, 0, 8'hF0, 64'h0, 0);
    // misaligned word store at offset 6, then loads that observe its effect
    run_req(1, 64'h8000_0006, 64'hDEADBEEF, 2'd2, 0, 64'h0, TRAP, 8'hC0, 64'hBEEF000000000000, 0);
    run_req(0, 64'h8000_0006, 64'h0, 2'd2, 0, TRAP ? 64'h0 : 64'hBEEF, TRAP, 8'hC0, 64'h0, 0);
    run_req(0, 64'h8000_0002, 64'h0, 2'd2, 0, 64'h0, TRAP, 8'h3C, 64'h0, 0);
    run_req(0, 64'h8000_0000, 64'h0, 2'd3, 0, TRAP ? 64'h80FF000000000000 : 64'hBEEF000000000000,
            0, 8'hFF, 64'h0, 0);

    // MEM_LAT=3 instance
    sel = 1'b1;
    run_req(1, 64'h8000_0008, 64'hCAFEF00D12345678, 2'd3, 0, 64'h0, 0, 8'hFF, 64'hCAFEF00D12345678, 0);
    run_req(0, 64'h8000_0008, 64'h0, 2'd3, 0, 64'hCAFEF00D12345678, 0, 8'hFF, 64'h0, 5);
    run_req(1, 64'h8000_000C, 64'h0BADF00D, 2'd2, 0, 64'h0, 0, 8'hF0, 64'h0BADF00D00000000, 5);

    // reset asserted in the second ACCESS cycle of a store
    @(negedge clk);
    resp_ready = 1'b1;
    req_we = 1'b1; req_addr = 64'h8000_0008; req_wdata = 64'h5555555555555555;
    req_size = 2'd3; req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_c1_we", 64'(o_we), 64'd0);
    check("rst_c1_ce", 64'(o_ce), 64'd1);
    @(posedge clk);
    #1 rst3_n = 1'b0;
    #1 check_reset_state("rst_mid");
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_we || o_ce || o_resp_valid) bad++;
    end
    rst3_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (o_we || o_ce || o_resp_valid) bad++;
    end
    check("rst_quiet", 64'(bad), 64'd0);
    check("rst_rdy", 64'(o_req_ready), 64'd1);
    run_req(0, 64'h8000_0008, 64'h0, 2'd3, 0, 64'h0BADF00D12345678, 0, 8'hFF, 64'h0, 0);

    check("sb_left", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store control stage directly upstream of the DPI-backed physical memory block. Accepts one load or store request from the pipeline over a valid/ready handshake and drives the memory port with a doubleword-aligned address, byte mask and lane-shifted write data. Extracts and extends load data, then returns a response over a second valid/ready handshake. Handles one request at a time; a configurable wait count models future multi-cycle memories.

Parameters:
MEM_LAT, 0, extra memory wait cycles per access (legal 0..15; 4-bit counter)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  stage can accept request
req_we  input  1  1=store, 0=load
req_addr  input  64  byte address
req_wdata  input  64  store data, right-aligned
req_size  input  2  0=byte 1=half 2=word 3=dword
req_unsigned  input  1  load zero-extend (1) / sign-extend (0)
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  64  extended load data; 0 for stores
resp_err  output  1  misaligned access (see Optional Feature)
mem_ce  output  1  memory chip enable
mem_we  output  1  memory write strobe
mem_addr  output  64  {addr[63:3],3'b000}
mem_wdata  output  64  req_wdata << (8*addr[2:0])
mem_wmask  output  8  byte enables
mem_rdata  input  64  combinational read data from memory

Behaviour:
- FSM states IDLE, ACCESS, RESP. Reset (rst_n low, async): state=IDLE, counter=0, all captured regs=0; mem_ce=mem_we=resp_valid=resp_err=0, resp_rdata=0, mem_* buses=0; req_ready=1 once in IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/size/unsigned, clear counter, go ACCESS.
- ACCESS: req_ready=0, mem_ce=1 for exactly MEM_LAT+1 cycles; counter increments each cycle. mem_we=req_we only in the final ACCESS cycle, so a store writes exactly once. On the final cycle, latch the extended load result from mem_rdata; go RESP.
- RESP: resp_valid=1, rdata/err stable until resp_valid&&resp_ready, then IDLE. No new request is accepted in the handshake cycle.
- Latency, MEM_LAT=0: accept at cycle t, ACCESS t+1, resp_valid t+2. Generally resp_valid at t+MEM_LAT+2.
- Mask: off=addr[2:0]. size0 8'h01<<off, size1 8'h03<<off, size2 8'h0F<<off, size3 8'hFF. Truncate shifts to 8 bits.
- Load: raw=mem_rdata>>(8*off). Keep the low 8/16/32/64 bits per size, then sign- or zero-extend per req_unsigned. size3 ignores req_unsigned.
- Outside ACCESS: mem_ce=mem_we=0, mem_wmask=0.
- Reset mid-ACCESS: FSM returns to IDLE immediately and mem_we drops. No write issues after reset asserts, and no response is produced.
- resp_ready held low: remain in RESP indefinitely with outputs stable.

Optional Feature:
LSU_MISALIGN_TRAP_EN. When defined, misaligned means size1&&off[0], size2&&off[1:0]!=0, or size3&&off!=0. A misaligned request goes IDLE->RESP directly with resp_err=1, resp_rdata=0 and no mem_ce/mem_we pulse. When undefined, resp_err is tied 0 and misaligned requests go through ACCESS normally. Bytes beyond the doubleword boundary are dropped by mask/shift truncation, and loads see zero in those bytes before extension.

Test Plan:
- MEM_LAT=0, store size3 addr 0x8000_0000 data 0x1122334455667788 -> one-cycle mem_we, wmask 0xFF, resp_valid at t+2, resp_rdata 0.
- Store byte 0xAB at 0x8000_0005 -> mem_addr 0x8000_0000, wmask 0x20, mem_wdata 0x0000AB0000000000.
- Memory word 0x80FF000000000000; load byte addr off 7, signed -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80. Half at off 6, signed -> 0xFFFFFFFFFFFF80FF.
- MEM_LAT=3, store -> mem_ce high 4 cycles, mem_we only on the 4th; resp_ready low 5 cycles -> resp_valid and data held, then IDLE after handshake.
- rst_n low during the 2nd ACCESS cycle with MEM_LAT=3 -> mem_we never pulses, state IDLE, req_ready=1 after release.
- LSU_MISALIGN_TRAP_EN defined, word load at off 2 -> resp_err=1 at t+1, mem_ce never asserted. Undefined -> access runs, wmask for a word store at off 6 = 0xC0.
